// File: rtl/imm_ext_arbiter_pkg.sv
// Shared widths, mode encodings, FSM states and the captured-request record
// for the immediate-extension arbiter.
package imm_ext_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  typedef enum logic [1:0] {
    MODE_SEXT  = 2'b00,
    MODE_ZEXT  = 2'b01,
    MODE_BR    = 2'b10,
    MODE_UPPER = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXT  = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic             owner;
    mode_t            mode;
    logic [IN_W-1:0]  imm;
  } cap_t;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle between the two immediate consumers and the arbiter.
interface imm_ext_arbiter_if;
  import imm_ext_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [IN_W-1:0]  req0_imm;
  logic [IN_W-1:0]  req1_imm;
  logic [1:0]       req0_mode;
  logic [1:0]       req1_mode;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [OUT_W-1:0] rsp_data;

  modport master (
    output req_valid, req0_imm, req1_imm, req0_mode, req1_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req0_imm, req1_imm, req0_mode, req1_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/imm_ext_arbiter_sext.sv
// Sign extension of a 16-bit immediate to 32 bits.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module SignExtension
  import imm_ext_pkg::*;
(
  input  logic [IN_W-1:0]  a,
  output logic [OUT_W-1:0] result
);

  assign result = {{(OUT_W-IN_W){a[IN_W-1]}}, a};

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin share of one SignExtension between ALU-imm (0) and branch (1).
// Latency: accept at N, rsp_valid at N+2; one transaction in flight.
// Backpressure: RESP holds data until rsp_ready[owner]; req_ready only in IDLE.
module imm_ext_arbiter
  import imm_ext_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  imm_ext_arbiter_if.slave bus
);

  state_t           state;
  cap_t             cap;
  logic             prio;
  logic [1:0]       grant;
  logic [1:0]       rsp_valid_q;
  logic [OUT_W-1:0] rsp_data_q;
  logic [OUT_W-1:0] se;
  logic [OUT_W-1:0] ext_res;

  // Grant is combinational so a lone requester is accepted in the same cycle;
  // gated by rst_n so req_ready reads 00 while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst_n && state == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  SignExtension u_sext (
    .a      (cap.imm),
    .result (se)
  );

  always_comb begin
    ext_res = se;
    case (cap.mode)
      MODE_SEXT:  ext_res = se;
      MODE_ZEXT:  ext_res = {{(OUT_W-IN_W){1'b0}}, cap.imm};
      MODE_BR:    ext_res = {se[OUT_W-3:0], 2'b00};
      MODE_UPPER: ext_res = {cap.imm, {(OUT_W-IN_W){1'b0}}};
      default:    ext_res = se;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap         <= '0;
      prio        <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            cap.owner <= grant[1];
            cap.mode  <= mode_t'(grant[1] ? bus.req1_mode : bus.req0_mode);
            cap.imm   <= grant[1] ? bus.req1_imm : bus.req0_imm;
            prio      <= ~grant[1];
            state     <= EXT;
          end
        end
        EXT: begin
          rsp_data_q  <= ext_res;
          rsp_valid_q <= cap.owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[cap.owner]) begin
            rsp_valid_q <= 2'b00;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed and randomized checks of imm_ext_arbiter against a behavioural model.
module tb_imm_ext_arbiter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  bit   mp;  // model round-robin preference

  imm_ext_arbiter_if bus ();

  imm_ext_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] imm);
    longint s;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(longint'(imm));
      2'd2:    return 32'(s * 4);
      default: return 32'(longint'(imm) * 65536);
    endcase
  endfunction

  // Entered just after a negedge with the DUT idle; serves every pending
  // requester, holding the owner's rsp_ready low for bp cycles each time.
  task automatic serve(input bit p0, input bit p1,
                       input logic [15:0] i0, input logic [15:0] i1,
                       input logic [1:0] m0, input logic [1:0] m1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input int bp);
    bit [1:0]    pend;
    bit          w;
    logic [1:0]  oh;
    logic [31:0] exp;
    pend = {p1, p0};
    bus.req0_imm  = i0;
    bus.req1_imm  = i1;
    bus.req0_mode = m0;
    bus.req1_mode = m1;
    for (int t = 0; t < 2 && pend != 2'b00; t++) begin
      w   = (pend == 2'b11) ? mp : pend[1];
      oh  = w ? 2'b10 : 2'b01;
      exp = w ? e1 : e0;
      bus.req_valid = pend;
      #1 chk("req_ready_grant", 32'(bus.req_ready), 32'(oh));
      @(posedge clk);
      mp      = ~w;
      pend[w] = 1'b0;
      @(negedge clk);
      bus.req_valid = pend;
      bus.rsp_ready = ~oh;
      #1;
      chk("ext_req_ready", 32'(bus.req_ready), 32'd0);
      chk("ext_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k <= bp; k++) begin
        chk("resp_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        chk("resp_rsp_data", bus.rsp_data, exp);
        chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
        if (k == bp) bus.rsp_ready = oh;
        @(posedge clk);
        @(negedge clk);
      end
      bus.rsp_ready = 2'b00;
      chk("after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    mp            = 1'b0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req0_imm  = '0;
    bus.req1_imm  = '0;
    bus.req0_mode = '0;
    bus.req1_mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    bus.req_valid = 2'b11;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);

    serve(1, 0, 16'h01DD, 16'h0, 2'd0, 2'd0, 32'h000001DD, 32'h0, 0);
    serve(0, 1, 16'h0, 16'hAFDE, 2'd0, 2'd0, 32'h0, 32'hFFFFAFDE, 0);
    serve(1, 0, 16'hAFDE, 16'h0, 2'd1, 2'd0, 32'h0000AFDE, 32'h0, 1);
    serve(0, 1, 16'h0, 16'hAFDE, 2'd0, 2'd2, 32'h0, 32'hFFFEBF78, 0);
    serve(1, 0, 16'hAFDE, 16'h0, 2'd3, 2'd0, 32'hAFDE0000, 32'h0, 2);

    // Abort a transaction in EXT, with both requesters waiting through reset.
    bus.req0_imm  = 16'h1234;
    bus.req0_mode = 2'd0;
    bus.req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req0_imm  = 16'h0001;
    bus.req0_mode = 2'd0;
    bus.req1_imm  = 16'hFFFF;
    bus.req1_mode = 2'd2;
    bus.req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_data", bus.rsp_data, 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mp    = 1'b0;
    #1 chk("postrst_req_ready", 32'(bus.req_ready), 32'd1);
    serve(1, 1, 16'h0001, 16'hFFFF, 2'd0, 2'd2, 32'h00000001, 32'hFFFFFFFC, 0);
    serve(1, 1, 16'h0001, 16'hFFFF, 2'd0, 2'd2, 32'h00000001, 32'hFFFFFFFC, 0);

    // After a lone requester-0 grant, requester 1 wins the tie and is held off
    // for 5 cycles while requester 0 keeps waiting.
    serve(1, 0, 16'h7FFF, 16'h0, 2'd0, 2'd0, 32'h00007FFF, 32'h0, 0);
    serve(1, 1, 16'h8000, 16'h4321, 2'd1, 2'd3, 32'h00008000, 32'h43210000, 5);

    for (int r = 0; r < 30; r++) begin
      bit          p0, p1;
      logic [15:0] i0, i1;
      logic [1:0]  m0, m1;
      p0 = 1'($urandom);
      p1 = 1'($urandom);
      if (!p0 && !p1) p1 = 1'b1;
      i0 = 16'($urandom);
      i1 = 16'($urandom);
      m0 = 2'($urandom);
      m1 = 2'($urandom);
      serve(p0, p1, i0, i1, m0, m1, ref_ext(m0, i0), ref_ext(m1, i1),
            int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Shares the single `SignExtension` instance (16→32) between two immediate consumers: port 0 is the ALU-immediate path and port 1 is the branch-target unit. The block arbitrates round-robin and sequences each accepted request through a three-state FSM. It applies the instruction-format variant (sign, zero, branch-offset, upper) and returns the registered 32-bit result to the requester that issued it.

## Interface
- `IN_W`, 16, immediate width; fixed, matches `SignExtension` input
- `OUT_W`, 32, extended result width; fixed, matches `SignExtension` output
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req_valid` in 2: per-requester request valid (bit i = requester i)
- `req_ready` out 2: per-requester accept; a request is accepted on the cycle `req_valid[i] & req_ready[i]`
- `req0_imm`, `req1_imm` in 16: immediate field
- `req0_mode`, `req1_mode` in 2: 00 SEXT, 01 ZEXT, 10 BR (sign-extend then <<2), 11 UPPER (imm<<16)
- `rsp_valid` out 2: result valid for requester i
- `rsp_ready` in 2: requester i takes the result
- `rsp_data` out 32: result, shared by both requesters and qualified by `rsp_valid`

## Operation
- FSM states are IDLE, EXT and RESP.
- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise grant one requester. `req_ready` is a combinational one-hot on the granted bit and asserts only in IDLE.
  - Capture `imm`, `mode` and owner id into registers, then go to EXT.
- **Arbitration**
  - A single valid requester wins.
  - If both are valid, the requester indicated by the `prio` pointer wins.
  - `prio` moves to the other requester after every grant.
  - Reset sets `prio` to 0.
- **EXT**
  - Drive the captured imm into `SignExtension`.
  - Compute the result by mode:
    - SEXT: `se`
    - ZEXT: `{16'h0, imm}`
    - BR: `{se[29:0], 2'b00}`
    - UPPER: `{imm, 16'h0}`
  - Register the result into `rsp_data`, then go to RESP.
- **RESP**
  - Assert `rsp_valid[owner]` and hold `rsp_data` stable.
  - On `rsp_ready[owner]`, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- The block holds one transaction in flight and never accepts a new request outside IDLE.
- Requesters must hold `req_valid`, imm and mode stable until accepted. The block may not drop a pending request, and the round-robin pointer guarantees the losing requester is granted within one transaction.
- No arithmetic overflow is flagged. In BR mode, bits shifted out of [31:30] are discarded.

## Timing
- Reset values: `req_ready`=00, `rsp_valid`=00, `rsp_data`=0, state IDLE, `prio`=0, internal capture registers 0.
- Accept at cycle N, then `rsp_valid` goes high at N+2 (N+1 is EXT).
- Minimum turnaround is 3 cycles per transaction: accept, EXT, RESP with `rsp_ready` already high, then IDLE.
- `req_ready` in IDLE is combinational from `req_valid` and `prio`. Every other output is registered.
- Backpressure: RESP persists while `rsp_ready[owner]`=0, with data unchanged.
- **Reset mid-operation:** `rst_n`=0 on any edge aborts the transaction. All outputs return to reset values on the next edge and the in-flight result is lost.
- **Simultaneous events:** a new `req_valid` arriving during RESP is not accepted until the cycle after the response handshake, when the FSM is back in IDLE.

## Structure
- Package `imm_ext_pkg` holds:
  - `IN_W`/`OUT_W` constants
  - mode encodings (`MODE_SEXT`, `MODE_ZEXT`, `MODE_BR`, `MODE_UPPER`)
  - FSM state enum
- Exactly one sub-module: the existing `SignExtension` (ports `a`, `result`), instantiated once.
- All other logic is inline: arbiter, FSM, mode mux, output register.

## Test plan
- **Sign extend, requester 0:** SEXT, imm 0x01DD → `rsp_valid`=01 two cycles after accept, `rsp_data`=0x000001DD.
- **All modes with imm 0xAFDE:**
  - SEXT → 0xFFFFAFDE
  - ZEXT → 0x0000AFDE
  - BR → 0xFFFEBF78
  - UPPER → 0xAFDE0000
- **Simultaneous requests:**
  - Both valid right after reset: req0 SEXT 0x0001 and req1 BR 0xFFFF → requester 0 served first (0x00000001), then requester 1 (0xFFFFFFFC).
  - Repeat with both valid again → requester 0 is granted first only if `prio` returned to 0; otherwise requester 1. Check alternation.
- **Backpressure:** hold `rsp_ready[1]`=0 for 5 cycles in RESP → `rsp_valid`=10 and `rsp_data` stable throughout, `req_ready` stays 00 although `req_valid[0]`=1.
- **Reset mid-EXT:** drive `rst_n` low in EXT → next edge `rsp_valid`=00, `rsp_data`=0, `req_ready`=00. After release the pending request is accepted in IDLE with requester 0 priority.
